// File: rtl/lutn_cfg_pkg.sv
// lutn_cfg_pkg: shared types and helpers for the reloadable K-input LUT.
//   lutn_state_t  - configuration FSM state (IDLE / LOAD)
//   lutn_depth(k) - truth-table depth 2**k
//   K_MAX         - largest supported LUT width
// Optional feature macro used by this block: LUTN_CFG_READBACK_EN.
package lutn_cfg_pkg;

   localparam int K_MAX = 6;

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } lutn_state_t;

   function automatic int lutn_depth(input int k);
      return 1 << k;
   endfunction

endpackage

// File: rtl/lutn_cfg_if.sv
// lutn_cfg_if: serial truth-table configuration bus.
//   cfg_start - one-cycle pulse starting a table load   (master -> slave)
//   cfg_din   - serial table bit, entry 0 first          (master -> slave)
//   cfg_busy  - high while the table is being shifted in (slave -> master)
//   cfg_done  - one-cycle pulse on the commit cycle       (slave -> master)
//   cfg_dout  - readback bit, only with LUTN_CFG_READBACK_EN defined
interface lutn_cfg_if;

   logic cfg_start;
   logic cfg_din;
   logic cfg_busy;
   logic cfg_done;

`ifdef LUTN_CFG_READBACK_EN
   logic cfg_dout;

   modport master (output cfg_start, output cfg_din,
                   input  cfg_busy,  input  cfg_done, input cfg_dout);
   modport slave  (input  cfg_start, input  cfg_din,
                   output cfg_busy,  output cfg_done, output cfg_dout);
`else
   modport master (output cfg_start, output cfg_din,
                   input  cfg_busy,  input  cfg_done);
   modport slave  (input  cfg_start, input  cfg_din,
                   output cfg_busy,  output cfg_done);
`endif

endinterface

// File: rtl/lutn_mux.sv
// lutn_mux: purely combinational 2**K:1 select of one truth-table entry.
//   tbl - truth table, bit j is the result for i == j
//   i   - select inputs
//   y   - selected entry
// Kept as its own module so the mapper packs it into LUT cells.
module lutn_mux
   import lutn_cfg_pkg::*;
#(
   parameter int K = 2
) (
   input  logic [lutn_depth(K)-1:0] tbl,
   input  logic [K-1:0]             i,
   output logic                     y
);

   assign y = tbl[i];

endmodule

// File: rtl/lutn_cfg.sv
// lutn_cfg: K-input LUT whose truth table is reloaded bit-serially into a
// shadow register and committed in one edge, so lookups never see a
// partially loaded table.
//   clk, rst_n - clock, asynchronous active-low reset
//   i          - LUT select inputs
//   o_ce       - output register enable (unused when REG_OUT = 0)
//   o          - LUT output
//   cfg        - lutn_cfg_if.slave configuration bus
// Optional feature macro: LUTN_CFG_READBACK_EN adds cfg.cfg_dout, a readback
// of active[rb_cnt] in IDLE; rb_cnt steps whenever i is all-ones and no
// cfg_start is present, and clears on commit.
//
// state | meaning
// IDLE  | table stable, waiting for cfg_start
// LOAD  | shifting one table bit per cycle into the shadow register
module lutn_cfg
   import lutn_cfg_pkg::*;
#(
   parameter int                    K       = 2,
   parameter logic [(1<<K)-1:0]     INIT    = '0,
   parameter bit                    REG_OUT = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [K-1:0]   i,
   input  logic           o_ce,
   output logic           o,
   lutn_cfg_if.slave      cfg
);

   localparam int N = lutn_depth(K);

   if (K < 1 || K > K_MAX) begin : g_bad_k
      $error("lutn_cfg: K must be in 1..K_MAX");
   end

   lutn_state_t  state;
   logic [K-1:0] cnt;
   logic [N-1:0] shadow;
   logic [N-1:0] active;
   logic [N-1:0] shadow_nxt;
   logic         busy;
   logic         done;
   logic         commit;
   logic         y;

   assign shadow_nxt = {cfg.cfg_din, shadow[N-1:1]};
   assign commit     = (state == LOAD) && (cnt == K'(N-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         shadow <= '0;
         active <= INIT;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg.cfg_start) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               shadow <= shadow_nxt;
               if (commit) begin
                  // last bit goes straight into the active table, bypassing shadow
                  active <= shadow_nxt;
                  cnt    <= '0;
                  state  <= IDLE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
               end else begin
                  cnt <= cnt + K'(1);
               end
            end
         endcase
      end
   end

   assign cfg.cfg_busy = busy;
   assign cfg.cfg_done = done;

   lutn_mux #(.K(K)) u_mux (
      .tbl (active),
      .i   (i),
      .y   (y)
   );

   if (REG_OUT) begin : g_reg_out
      logic o_q;
      // samples the table active before the edge, so the commit edge still sees the old table
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            o_q <= 1'b0;
         end else if (o_ce) begin
            o_q <= y;
         end
      end
      assign o = o_q;
   end else begin : g_comb_out
      logic unused_o_ce;
      assign unused_o_ce = o_ce;
      assign o = y;
   end

`ifdef LUTN_CFG_READBACK_EN
   logic [K-1:0] rb_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rb_cnt <= '0;
      end else if (commit) begin
         rb_cnt <= '0;
      end else if (!cfg.cfg_start && (&i)) begin
         rb_cnt <= rb_cnt + K'(1);
      end
   end

   assign cfg.cfg_dout = (state == IDLE) ? active[rb_cnt] : 1'b0;
`endif

endmodule
